serial_rx_fifo: RTL



---
 rtl/serial_rx_fifo_if.sv | 27 ++
 rtl/serial_rx_fifo.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_rx_fifo_if.sv
// serial_rx_fifo_if: register-access bus between the O-CPU port decoder and the buffered
// UART receiver.
//   en       - access strobe (decoded upstream from the port ID and read/write strobes)
//   wr       - 1 = write, 0 = read
//   addr     - 0 = data register, 1 = status register
//   data_in  - write data
//   data_out - read data, combinational from addr
//   ready    - receive FIFO not empty (interrupt level)
// master: CPU side. slave: receiver side.
interface serial_rx_fifo_if;
  logic       en;
  logic       wr;
  logic       addr;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       ready;

  modport master (
    output en, wr, addr, data_in,
    input  data_out, ready
  );

  modport slave (
    input  en, wr, addr, data_in,
    output data_out, ready
  );
endinterface

// File: rtl/serial_rx_fifo.sv
// serial_rx_fifo: buffered 16x-oversampling UART receiver for the O-CPU port bus.
// Frames are 8N1 by default. Defining SERIAL_RX_PARITY_EN switches to 8E1 and adds the
// parity-error flag (status bit 4).
// Ports:
//   clk   - system clock
//   reset - asynchronous, active-high reset
//   rxd   - asynchronous serial input, idle high
//   bus   - register bus (slave modport): data/status reads, status-clear writes, ready
// Registers: read 0 = FIFO head (0x00 when empty); read 1 = {3'b0, parity_err, frame_err,
// overrun, full, not_empty}; write 1 clears the error flags; write 0 is ignored.
module serial_rx_fifo #(
  parameter int unsigned CLK_HZ  = 50000000,
  parameter int unsigned BAUD    = 115200,
  parameter int unsigned FIFO_AW = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rxd,
  serial_rx_fifo_if.slave  bus
);

  localparam int unsigned DivRaw = CLK_HZ / (16 * BAUD);
  localparam int unsigned Div    = (DivRaw == 0) ? 1 : DivRaw;
  localparam int unsigned Depth  = 1 << FIFO_AW;

  // Input synchronizer, reset to the idle level.
  logic rxd_s1, rxd_s;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rxd_s1 <= 1'b1;
      rxd_s  <= 1'b1;
    end else begin
      rxd_s1 <= rxd;
      rxd_s  <= rxd_s1;
    end
  end

  // Free-running 16x baud tick.
  logic [31:0] tick_cnt;
  logic        tick;
  assign tick = (tick_cnt == 32'(Div - 1));
  always_ff @(posedge clk or posedge reset) begin
    if (reset) tick_cnt <= '0;
    else       tick_cnt <= tick ? '0 : tick_cnt + 32'd1;
  end

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef SERIAL_RX_PARITY_EN
    StParity,
`endif
    StStop,
    StBreak
  } state_e;

  state_e     state;
  logic [3:0] sub_cnt;
  logic [2:0] bit_idx;
  logic [7:0] shreg;
  logic       push_q;
  logic       frame_set_q;
`ifdef SERIAL_RX_PARITY_EN
  logic       par_bad_q;
  logic       par_set_q;
`endif

  // Receive FSM; push/flag-set outputs are registered one-cycle pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= StIdle;
      sub_cnt     <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      push_q      <= 1'b0;
      frame_set_q <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      par_bad_q   <= 1'b0;
      par_set_q   <= 1'b0;
`endif
    end else begin
      push_q      <= 1'b0;
      frame_set_q <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      par_set_q   <= 1'b0;
`endif
      if (tick) begin
        case (state)
          StIdle: begin
            if (!rxd_s) begin
              state   <= StStart;
              sub_cnt <= '0;
            end
          end
          StStart: begin
            // Mid-start-bit check rejects glitches shorter than half a bit.
            if (sub_cnt == 4'd7) begin
              sub_cnt <= '0;
              bit_idx <= '0;
              state   <= rxd_s ? StIdle : StData;
            end else begin
              sub_cnt <= sub_cnt + 4'd1;
            end
          end
          StData: begin
            sub_cnt <= sub_cnt + 4'd1;  // wraps to 0 after each mid-bit sample
            if (sub_cnt == 4'd15) begin
              shreg   <= {rxd_s, shreg[7:1]};
              bit_idx <= bit_idx + 3'd1;
              if (bit_idx == 3'd7) begin
`ifdef SERIAL_RX_PARITY_EN
                state <= StParity;
`else
                state <= StStop;
`endif
              end
            end
          end
`ifdef SERIAL_RX_PARITY_EN
          StParity: begin
            sub_cnt <= sub_cnt + 4'd1;
            if (sub_cnt == 4'd15) begin
              par_bad_q <= rxd_s ^ (^shreg);  // even parity: total ones must be even
              state     <= StStop;
            end
          end
`endif
          StStop: begin
            sub_cnt <= sub_cnt + 4'd1;
            if (sub_cnt == 4'd15) begin
              if (rxd_s) begin
`ifdef SERIAL_RX_PARITY_EN
                if (par_bad_q) par_set_q <= 1'b1;
                else           push_q    <= 1'b1;
`else
                push_q <= 1'b1;
`endif
                state <= StIdle;
              end else begin
                frame_set_q <= 1'b1;
                state       <= StBreak;
              end
            end
          end
          StBreak: begin
            if (rxd_s) state <= StIdle;
          end
          default: state <= StIdle;
        endcase
      end
    end
  end

  // FIFO
  logic [7:0]         mem [Depth];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count, count_d;
  logic               ready_q;
  logic               full, not_empty, pop, do_push;

  assign full      = (count == (FIFO_AW + 1)'(Depth));
  assign not_empty = (count != '0);
  assign pop       = bus.en & ~bus.wr & ~bus.addr & not_empty;
  // A push into a full FIFO still lands when a pop frees the slot in the same cycle.
  assign do_push   = push_q & (~full | pop);

  always_comb begin
    count_d = count;
    if (do_push && !pop)      count_d = count + 1'b1;
    else if (pop && !do_push) count_d = count - 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ready_q <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      count   <= count_d;
      ready_q <= (count_d != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= shreg;
  end

  // Sticky error flags; a set in the same cycle as a clear wins.
  logic clr, overrun, frame_err, parity_err;
  assign clr = bus.en & bus.wr & bus.addr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (push_q && full && !pop) overrun <= 1'b1;
      else if (clr)               overrun <= 1'b0;
      if (frame_set_q)            frame_err <= 1'b1;
      else if (clr)               frame_err <= 1'b0;
    end
  end

`ifdef SERIAL_RX_PARITY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          parity_err <= 1'b0;
    else if (par_set_q) parity_err <= 1'b1;
    else if (clr)       parity_err <= 1'b0;
  end
`else
  assign parity_err = 1'b0;
`endif

  always_comb begin
    if (bus.addr) bus.data_out = {3'b000, parity_err, frame_err, overrun, full, not_empty};
    else          bus.data_out = not_empty ? mem[rd_ptr] : 8'h00;
  end

  assign bus.ready = ready_q;

  logic unused_data_in;
  assign unused_data_in = ^bus.data_in;

endmodule
